// File: rtl/instr_sequencer.sv
// Program sequencer for the 4-bit CPU core instruction bus.
// Holds a small instruction store, loaded over a write port while not running, and issues the
// stored words in order, following each one with GAP NOP cycles so that registered ALU/RAM
// results settle before the next instruction.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   prog_we/addr/data      program store write port (ignored while busy)
//   start, step, stop      run control pulses (priority stop > start > step)
//   last_addr, loop_en     final program address; wrap to 0 instead of finishing
//   instruction            registered word to the core (NOP_INSTR when not issuing)
//   instr_valid            high in cycles carrying a real stored word
//   pc                     address of the next word to issue
//   busy                   high while running (issue or gap state)
//   done                   one-cycle pulse on normal completion
module instr_sequencer #(
  parameter int unsigned   DEPTH     = 16,
  parameter int unsigned   AW        = 4,
  parameter int unsigned   IW        = 11,
  parameter logic [IW-1:0] NOP_INSTR = '0,
  parameter int unsigned   GAP       = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  input  logic          step,
  input  logic          stop,
  input  logic [AW-1:0] last_addr,
  input  logic          loop_en,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam bit       HasGap  = (GAP > 0);
  localparam logic [2:0] GapLast = HasGap ? 3'(GAP - 1) : 3'd0;

  typedef enum logic [1:0] {StIdle, StRunIssue, StRunGap, StPause} state_e;

  logic [IW-1:0] mem_q [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [2:0]    gap_cnt_q, gap_cnt_d;
  logic          fin_q, fin_d;     // final word issued, completion pending
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          halted;
  logic          do_issue;
  logic [AW-1:0] issue_addr;
  logic          at_last;

  assign halted     = (state_q == StIdle) || (state_q == StPause);
  // A start from a halted state always issues from address 0.
  assign issue_addr = (halted && start) ? '0 : pc_q;
  assign at_last    = (issue_addr == last_addr);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    gap_cnt_d = gap_cnt_q;
    fin_d     = fin_q;
    instr_d   = NOP_INSTR;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    do_issue  = 1'b0;

    unique case (state_q)
      StIdle, StPause: begin
        if (stop) begin
          // Nothing to halt; hold.
        end else if (start) begin
          do_issue  = 1'b1;
          fin_d     = at_last && !loop_en;
          gap_cnt_d = '0;
          state_d   = HasGap ? StRunGap : StRunIssue;
        end else if (step) begin
          do_issue = 1'b1;
          fin_d    = 1'b0;
          if (at_last && !loop_en) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StPause;
          end
        end
      end
      StRunIssue: begin
        if (stop) begin
          state_d   = StPause;
          gap_cnt_d = '0;
          fin_d     = 1'b0;
        end else if (fin_q) begin
          state_d = StIdle;
          pc_d    = '0;
          done_d  = 1'b1;
          fin_d   = 1'b0;
        end else begin
          do_issue  = 1'b1;
          fin_d     = at_last && !loop_en;
          gap_cnt_d = '0;
          state_d   = HasGap ? StRunGap : StRunIssue;
        end
      end
      StRunGap: begin
        if (stop) begin
          state_d   = StPause;
          gap_cnt_d = '0;
          fin_d     = 1'b0;
        end else if (gap_cnt_q == GapLast) begin
          state_d   = StRunIssue;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_issue) begin
      instr_d = mem_q[issue_addr];
      valid_d = 1'b1;
      pc_d    = at_last ? '0 : issue_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      gap_cnt_q <= '0;
      fin_q     <= 1'b0;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      gap_cnt_q <= gap_cnt_d;
      fin_q     <= fin_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  // Program store is deliberately not reset so a program survives reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign busy        = (state_q == StRunIssue) || (state_q == StRunGap);
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign done        = done_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer that drives the 11-bit instruction bus of the 4-bit CPU core.
- Holds a 16-entry instruction store, loaded over a simple write port.
- Issues stored words in order under start/step/stop control, with a programmable number of NOP cycles after each word so the registered ALU and RAM results settle before the next instruction.
- Sits between the test/host interface and the CPU core's instruction input.

Parameters:
- DEPTH, 16, number of program words.
- AW, 4, program address / pc width.
- IW, 11, instruction width; matches the core's instruction bus.
- NOP_INSTR, 11'h000, word driven whenever no instruction is being issued.
- GAP, 1, NOP cycles inserted after each issued word; legal range 0..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- prog_we  input  1  program write strobe.
- prog_addr  input  4  program write address.
- prog_data  input  11  program write data.
- start  input  1  pulse: run from address 0.
- step  input  1  pulse: issue one word at pc.
- stop  input  1  pulse: halt issuing, keep pc.
- last_addr  input  4  address of final program word.
- loop_en  input  1  1 = wrap to 0 after last_addr; 0 = finish.
- instruction  output  11  registered instruction to the CPU core.
- instr_valid  output  1  high in cycles carrying a real stored word.
- pc  output  4  address of the next word to issue.
- busy  output  1  high in RUN_ISSUE/RUN_GAP.
- done  output  1  one-cycle pulse on normal program completion.

Behaviour:
- One clock (clk); reset_n is asynchronous, active-low.
- Reset values:
  - instruction=NOP_INSTR, instr_valid=0, pc=0, busy=0, done=0, state=IDLE.
  - Program store is not reset; contents survive reset.
- All outputs are registered.
  - An action decided at edge N is visible from edge N until edge N+1.
- States: IDLE, RUN_ISSUE, RUN_GAP, PAUSE.
- Control priority when sampled together: stop > start > step.
- Issue action at edge N:
  - instruction<=mem[pc], instr_valid<=1.
  - pc advances: pc+1; at pc==last_addr it goes to 0.
- Non-issue edges: instruction<=NOP_INSTR, instr_valid<=0.
- IDLE:
  - start: pc treated as 0; issue mem[0] at the same edge. Then RUN_GAP if GAP>0, else stay in RUN_ISSUE.
  - step: issue at pc, go to PAUSE.
- RUN_ISSUE: issue at pc, then RUN_GAP (GAP>0) or stay.
- RUN_GAP: holds NOP for exactly GAP cycles via a 3-bit counter, then returns to RUN_ISSUE.
  - Issue period is therefore GAP+1 cycles.
- Completion (loop_en=0): after the word at last_addr and its GAP cycles, the next edge:
  - state<=IDLE, pc<=0, done<=1 for one cycle, no issue.
- loop_en=1: issue wraps to mem[0] with no extra cycle and never completes.
  - loop_en is sampled at the issue of last_addr.
- stop in RUN_ISSUE/RUN_GAP:
  - The next edge drives NOP, valid=0 and goes to PAUSE.
  - pc holds the next unissued address; the gap counter clears; no done.
- PAUSE:
  - step: issue at pc, stay in PAUSE.
  - If the stepped word was last_addr with loop_en=0: pc<=0, done pulses, state<=IDLE.
  - start: restart from address 0, as from IDLE.
- busy=1 exactly in RUN_ISSUE/RUN_GAP.
- Program writes:
  - prog_we accepted only when busy=0; mem[prog_addr]<=prog_data at the edge.
  - Writes while busy=1 are dropped silently.
  - A write and a step at the same edge: the issue reads the old contents.
- last_addr is sampled continuously. Changing it mid-run takes effect at the next issue comparison.
- GAP=0: instr_valid stays high continuously in RUN_ISSUE and one word is issued per cycle.
- Reset asserted mid-run: immediate return to reset values; the next start begins at 0.

Test Plan:
- Load mem[0..3]=11'h101,11'h202,11'h303,11'h404; last_addr=3, loop_en=0, GAP=1; start -> words on cycles 0,2,4,6 with valid=1, NOP valid=0 between; done pulses on cycle 8; pc=0, busy=0 after.
- Same program, loop_en=1 -> after 11'h404 + 1 gap, 11'h101 is reissued; no done over 20 cycles.
- Run, then stop pulsed while 11'h202 is visible -> next cycle NOP, PAUSE, pc=2. Then step twice -> 11'h303 then 11'h404, done pulses after the second step, state IDLE.
- Write attempts while busy=1 (addr 1, data 11'h7FF) -> a rerun still issues 11'h202 at address 1. Write in IDLE -> a rerun issues 11'h7FF.
- GAP=0, last_addr=2 -> three consecutive cycles with valid=1, then done; stop+start together -> stop wins.
- Assert reset_n low mid-run for a partial cycle -> outputs immediately NOP/0. After release, start reissues mem[0] with contents intact.
